// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the BCD to Excess-3 sequencer.
//   state_t     : FSM state encoding (2 bits)
//   XS3_OFFSET  : value added to a legal BCD digit
//   BCD_MAX     : largest legal BCD digit
//   CNT_W       : digit counter width (covers up to 8 digits)
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         CNT_W      = 3;

endpackage

// File: rtl/bcd_xs3_digit.sv
// bcd_xs3_digit -- combinational single-digit BCD to Excess-3 converter.
//   d   : input BCD nibble
//   x   : Excess-3 nibble (d+3 for 0..9, 0 for an illegal nibble)
//   err : high when d is not a legal BCD digit
module bcd_xs3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] x,
  output logic       err
);

  always_comb begin
    err = (d > BCD_MAX);
    // 4-bit add, carry discarded; legal digits never overflow anyway.
    x   = err ? 4'd0 : (d + XS3_OFFSET);
  end

endmodule

// File: rtl/bcd_xs3_sequencer.sv
// bcd_xs3_sequencer -- converts a packed BCD word into packed Excess-3,
// one digit per clock, using a single time-shared digit converter.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream word present
//   in_ready  : block accepts a word this cycle (high only in IDLE)
//   in_bcd    : packed BCD word, digit 0 in bits [3:0]
//   out_valid : result present (high only in DONE)
//   out_ready : downstream takes the result this cycle
//   out_xs3   : packed Excess-3 result, digit 0 in bits [3:0]
//   out_err   : at least one input nibble was above 9
// Timing: counting the accepting edge as edge 1, out_valid rises on edge
// NDIG+1; with the DONE handshake and one IDLE cycle a word can be taken
// every NDIG+2 cycles.
module bcd_xs3_sequencer
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_xs3,
  output logic              out_err
);

  localparam int W = 4 * NDIG;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     operand_reg, operand_next;
  logic [W-1:0]     result_reg, result_next;
  logic             err_reg, err_next;

  logic [3:0]       cur_d;
  logic [3:0]       cur_x;
  logic             cur_err;

  // Select the operand digit addressed by the counter.
  always_comb begin
    cur_d = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_reg == CNT_W'(i)) cur_d = operand_reg[4*i +: 4];
    end
  end

  bcd_xs3_digit u_digit (
    .d   (cur_d),
    .x   (cur_x),
    .err (cur_err)
  );

  // Next-state and datapath update.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    operand_next = operand_reg;
    result_next  = result_reg;
    err_next     = err_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          operand_next = in_bcd;
          cnt_next     = '0;
          result_next  = '0;
          err_next     = 1'b0;
          state_next   = ST_CONV;
        end
      end
      ST_CONV: begin
        for (int i = 0; i < NDIG; i++) begin
          if (cnt_reg == CNT_W'(i)) result_next[4*i +: 4] = cur_x;
        end
        // Error flag is sticky for the rest of the word.
        err_next = err_reg | cur_err;
        if (cnt_reg == LAST_IDX) state_next = ST_DONE;
        else                     cnt_next   = cnt_reg + 1'b1;
      end
      ST_DONE: begin
        // Returning to IDLE here means no word is taken on the handshake edge.
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Single clocked process for all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      operand_reg <= '0;
      result_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      operand_reg <= operand_next;
      result_reg  <= result_next;
      err_reg     <= err_next;
    end
  end

  // Handshake flags decode from state only.
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
  end

  assign out_xs3 = result_reg;
  assign out_err = err_reg;

endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// tb_bcd_xs3_sequencer -- self-checking bench for bcd_xs3_sequencer (NDIG=4).
// Directed words, stalls, mid-conversion reset, back-to-back streaming and
// randomized words, all checked against a digit-by-digit arithmetic model.
module tb_bcd_xs3_sequencer;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bcd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_xs3;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  bcd_xs3_sequencer #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each digit independently, value+3 if legal else 0 and flag.
  task automatic model(input logic [W-1:0] w, output logic [W-1:0] x, output logic e);
    int d;
    x = '0;
    e = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      d = int'((w >> (4 * i)) & 16'hF);
      if (d > 9) e = 1'b1;
      else x = x | (W'(d + 3) << (4 * i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, stall 'stall' cycles in
  // DONE (out_ready held 1 throughout when stall is 0), then handshake.
  task automatic run_word(input logic [W-1:0] w, input int stall);
    logic [W-1:0] exp_x;
    logic         exp_e;
    int           n;
    int           lat;
    model(w, exp_x, exp_e);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_bcd    = w;
    out_ready = (stall == 0);
    tick();
    check("accepted", 32'(in_ready), 32'd0);
    // Noise while converting must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    in_bcd   = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      in_bcd = W'($urandom);
    end
    check("latency", 32'(lat), 32'(NDIG));
    check("xs3", 32'(out_xs3), 32'(exp_x));
    check("err", 32'(out_err), 32'(exp_e));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_xs3", 32'(out_xs3), 32'(exp_x));
      check("hold_err", 32'(out_err), 32'(exp_e));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("valid_drop", 32'(out_valid), 32'd0);
    check("idle_after_hs", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    $display("word in=%h out=%h err=%0d exp=%h/%0d lat=%0d stall=%0d",
             w, out_xs3, out_err, exp_x, exp_e, lat, stall);
  endtask

  logic [W-1:0] exp_q_x[$];
  logic         exp_q_e[$];

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] mx;
    logic         me;
    int           last_acc;
    int           accepts;
    int           outs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_xs3", 32'(out_xs3), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed words; first one is accepted on the first edge out of reset.
    run_word(16'h1234, 0);
    run_word(16'h9990, 1);
    run_word(16'h0000, 0);
    run_word(16'h12A4, 2);
    run_word(16'h0001, 0);
    run_word(16'hFFFF, 0);
    run_word(16'h9876, 6);

    // Reset in the middle of conversion (counter = 2).
    in_valid = 1'b1;
    in_bcd   = 16'h5678;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_xs3", 32'(out_xs3), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("postrst_no_valid", 32'(out_valid), 32'd0);
    end
    $display("reset during conversion: word discarded");
    run_word(16'h4321, 0);

    // Back-to-back streaming with in_valid and out_ready held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_bcd    = 16'h0123;
    last_acc  = -1;
    accepts   = 0;
    outs      = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        if (exp_q_x.size() == 0) begin
          check("stream_unexpected", 32'd1, 32'd0);
        end else begin
          mx = exp_q_x.pop_front();
          me = exp_q_e.pop_front();
          check("stream_xs3", 32'(out_xs3), 32'(mx));
          check("stream_err", 32'(out_err), 32'(me));
          $display("stream out=%h err=%0d exp=%h/%0d", out_xs3, out_err, mx, me);
          outs++;
        end
      end
      if (in_ready) begin
        model(in_bcd, mx, me);
        exp_q_x.push_back(mx);
        exp_q_e.push_back(me);
        if (last_acc >= 0) check("stream_period", 32'(c - last_acc), 32'(NDIG + 2));
        last_acc = c;
        accepts++;
      end
      tick();
      in_bcd = W'($urandom);
    end
    in_valid  = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd10);
    n_drain: for (int c = 0; c < 10; c++) begin
      if (out_valid && exp_q_x.size() != 0) begin
        mx = exp_q_x.pop_front();
        me = exp_q_e.pop_front();
        check("drain_xs3", 32'(out_xs3), 32'(mx));
        check("drain_err", 32'(out_err), 32'(me));
        outs++;
      end
      tick();
    end
    check("stream_outs", 32'(outs), 32'(accepts));
    out_ready = 1'b0;

    // Randomized words: mostly legal BCD, some illegal nibbles.
    for (int k = 0; k < 30; k++) begin
      w = '0;
      for (int i = 0; i < NDIG; i++) begin
        if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
        else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_word(w, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
